// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce.
// Emits a one-cycle key_valid pulse with the hex code of each debounced press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 24000,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_sync,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int SW  = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0]  DWELL_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  // Nibble {row,col} of this constant is the hex label of that key.
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t         state_q, state_d;
  logic [1:0]     row_idx_q, row_idx_d;
  logic [SW-1:0]  dwell_q, dwell_d;
  logic [DBW-1:0] db_q, db_d;
  logic [3:0]     col_pat_q, col_pat_d;
  logic [1:0]     col_idx_q, col_idx_d;
  logic [3:0]     key_code_q, key_code_d;
  logic           key_valid_q, key_valid_d;
  logic           key_held_q, key_held_d;
  logic           one_low;
  logic [1:0]     col_enc;

  assign one_low = $onehot(~col_sync);
  assign col_enc = !col_sync[0] ? 2'd0 : !col_sync[1] ? 2'd1 : !col_sync[2] ? 2'd2 : 2'd3;

  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    dwell_d     = dwell_q;
    db_d        = db_q;
    col_pat_d   = col_pat_q;
    col_idx_d   = col_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (one_low) begin
            state_d   = PRESS_DB;
            db_d      = '0;
            col_pat_d = col_sync;
            col_idx_d = col_enc;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      PRESS_DB: begin
        if (col_sync != col_pat_q) begin
          state_d   = SCAN;
          db_d      = '0;
          dwell_d   = '0;
          row_idx_d = row_idx_q + 2'd1;
        end else if (db_q == DB_LAST) begin
          state_d     = HELD;
          db_d        = '0;
          key_valid_d = 1'b1;
          key_code_d  = KEYMAP[{row_idx_q, col_idx_q, 2'b00} +: 4];
          key_held_d  = 1'b1;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      HELD: begin
        if (col_sync[col_idx_q]) begin
          state_d = RELEASE_DB;
          db_d    = '0;
        end
      end
      RELEASE_DB: begin
        // A low latched column before completion is contact bounce, not a new press.
        if (!col_sync[col_idx_q]) begin
          state_d = HELD;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d    = SCAN;
          db_d       = '0;
          dwell_d    = '0;
          key_held_d = 1'b0;
          row_idx_d  = row_idx_q + 2'd1;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      row_idx_q   <= '0;
      dwell_q     <= '0;
      db_q        <= '0;
      col_pat_q   <= 4'hF;
      col_idx_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
      col_pat_q   <= col_pat_d;
      col_idx_q   <= col_idx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign row       = ~(4'b0001 << row_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
endmodule
